// File: rtl/plot_sink_pkg.sv
// rtl/plot_sink_pkg.sv - shared constants, request layout, FSM encoding and address helper for plot_sink
package plot_sink_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 3;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int REQ_W     = X_W + Y_W + COLOUR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } plot_req_t;

    // y*160 built from two shifts so no multiplier is needed
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = FB_ADDR_W'(y);
        return (yw << 7) + (yw << 5) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous plot request FIFO with head/next peek and same-cycle push/pop
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 18
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          head_data,
    output logic [DW-1:0]          next_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_ptr_q + AW'(1)];

    // Pointer and occupancy update; a push into a full FIFO or pop from empty is ignored
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - pixel plot sink: request FIFO, range check, framebuffer writer, screen clear (optional PLOT_SINK_DROP_CNT_EN)
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int                  WIDTH        = SCREEN_W,
    parameter int                  HEIGHT       = SCREEN_H,
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic [COLOUR_W-1:0]   colour,
    input  logic                  plot,
    output logic                  plot_ready,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [FB_ADDR_W-1:0]  mem_addr,
    output logic [COLOUR_W-1:0]   mem_data,
    output logic                  mem_we,
    input  logic                  mem_ready
`ifdef PLOT_SINK_DROP_CNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [X_W-1:0]       X_LIM     = X_W'(WIDTH);
    localparam logic [Y_W-1:0]       Y_LIM     = Y_W'(HEIGHT);
    localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(WIDTH * HEIGHT - 1);

    state_e                state_q, state_d;
    logic [FB_ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOUR_W-1:0]   data_q, data_d;
    logic                  clear_pend_q, clear_pend_d;

    plot_req_t             push_req, head_req, next_req, follow_req;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  in_range, accept, fifo_push, fifo_pop, more_after_pop;

    assign in_range  = (x < X_LIM) && (y < Y_LIM);
    assign accept    = plot && plot_ready;
    assign fifo_push = accept && in_range;
    assign fifo_pop  = (state_q == WRITE) && mem_ready;
    assign push_req  = '{x: x, y: y, colour: colour};

    // The entry after the one being retired: either already queued, or arriving on this very edge
    assign more_after_pop = (fifo_count > CW'(1)) || fifo_push;
    assign follow_req     = (fifo_count > CW'(1)) ? next_req : push_req;

    assign plot_ready = !fifo_full && (state_q != CLEAR);
    assign busy       = (state_q != IDLE) || !fifo_empty || clear_pend_q;
    assign mem_we     = (state_q != IDLE);
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (REQ_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head_data (head_req),
        .next_data (next_req),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic; the FIFO head stays queued until its write completes
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        clear_pend_d = clear_pend_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    data_d  = CLEAR_COLOUR;
                end else if (!fifo_empty) begin
                    state_d = WRITE;
                    addr_d  = fb_addr(head_req.x, head_req.y);
                    data_d  = head_req.colour;
                end
            end
            WRITE: begin
                if (clear_req) begin
                    clear_pend_d = 1'b1;
                end
                if (mem_ready) begin
                    if (clear_pend_q || clear_req) begin
                        state_d      = CLEAR;
                        addr_d       = '0;
                        data_d       = CLEAR_COLOUR;
                        clear_pend_d = 1'b0;
                    end else if (more_after_pop) begin
                        addr_d = fb_addr(follow_req.x, follow_req.y);
                        data_d = follow_req.colour;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (mem_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + FB_ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and write-port registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            clear_pend_q <= clear_pend_d;
        end
    end

`ifdef PLOT_SINK_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic       clear_start;

    assign clear_start = (state_q != CLEAR) && (state_d == CLEAR);
    assign drop_count  = drop_q;

    // Saturating count of out-of-range requests; a new clear sequence restarts it
    always_comb begin
        drop_d = drop_q;
        if (clear_start) begin
            drop_d = '0;
        end else if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - randomized and directed bench for plot_sink against a write-order queue model (optional PLOT_SINK_DROP_CNT_EN)
module tb_plot_sink;

    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = 160 * 120;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        plot_ready;
    logic        clear_req;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
`ifdef PLOT_SINK_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    plot_sink dut (
        .clock      (clock),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .plot_ready (plot_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready)
`ifdef PLOT_SINK_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected write stream: pixel writes in acceptance order, a clear is one marker covering 19200 writes
    typedef struct {
        bit is_clear;
        int addr;
        int data;
    } exp_t;

    exp_t        q[$];
    int          clear_idx    = 0;
    bit          clear_active = 1'b0;
    int          model_drop   = 0;
    int          pend;
    bit          stall_prev   = 1'b0;
    logic [14:0] stall_addr;
    logic [2:0]  stall_data;
    exp_t        m;

    // Model update and checks; inputs and outputs are stable here and describe the coming rising edge
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            clear_idx    = 0;
            clear_active = 1'b0;
            model_drop   = 0;
            stall_prev   = 1'b0;
        end else begin
            pend = 0;
            foreach (q[i]) if (!q[i].is_clear) pend++;
            check("plot_ready", plot_ready, (!clear_active && pend < FIFO_DEPTH));
            check("busy", busy, (q.size() != 0));
`ifdef PLOT_SINK_DROP_CNT_EN
            check("drop_count", drop_count, model_drop);
`endif
            if (stall_prev && mem_we) begin
                check("stall_addr", mem_addr, stall_addr);
                check("stall_data", mem_data, stall_data);
            end
            stall_prev = mem_we && !mem_ready;
            stall_addr = mem_addr;
            stall_data = mem_data;

            if (clear_req && !clear_active) begin
                m.is_clear = 1'b1; m.addr = 0; m.data = 0;
                if (mem_we) begin
                    if (q.size() > 0 && !(q.size() > 1 && q[1].is_clear)) q.insert(1, m);
                end else begin
                    q.push_front(m);
                end
            end

            if (plot && plot_ready) begin
                if (x < 160 && y < 120) begin
                    m.is_clear = 1'b0;
                    m.addr     = int'(y) * 160 + int'(x);
                    m.data     = int'(colour);
                    q.push_back(m);
                end else if (model_drop < 255) begin
                    model_drop++;
                end
            end

            if (mem_we && mem_ready) begin
                if (q.size() == 0) begin
                    check("spurious_write", mem_we, 0);
                end else if (q[0].is_clear) begin
                    check("clear_addr", mem_addr, clear_idx);
                    check("clear_data", mem_data, 0);
                    clear_idx++;
                    if (clear_idx == NPIX) begin
                        void'(q.pop_front());
                        clear_idx    = 0;
                        clear_active = 1'b0;
                    end
                end else begin
                    check("write_addr", mem_addr, q[0].addr);
                    check("write_data", mem_data, q[0].data);
                    void'(q.pop_front());
                end
            end

            if (q.size() > 0 && q[0].is_clear && !clear_active) begin
                clear_active = 1'b1;
                model_drop   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            tick();
            t++;
        end
        check(tag, busy, 0);
        check({tag, "_queue"}, q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        bit  acc;

        reset = 1'b1; plot = 1'b0; clear_req = 1'b0; mem_ready = 1'b1;
        x = '0; y = '0; colour = '0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_plot_ready", plot_ready, 1);
`ifdef PLOT_SINK_DROP_CNT_EN
        check("rst_drop_count", drop_count, 0);
`endif
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single plot: mem_we two edges after the accepting edge
        plot = 1'b1; x = 8'd10; y = 7'd5; colour = 3'b011;
        tick();
        plot = 1'b0;
        check("t1_we_after_accept", mem_we, 0);
        tick();
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 810);
        check("t1_data", mem_data, 3);
        tick();
        check("t1_we_done", mem_we, 0);
        check("t1_busy", busy, 0);

        // Five back-to-back plots against a stalled memory
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            plot = 1'b1; x = 8'(i * 37 + 3); y = 7'(i * 29 + 1); colour = 3'(i + 4);
            tick();
        end
        check("t2_full_ready", plot_ready, 0);
        x = 8'd159; y = 7'd119; colour = 3'd6;
        tick(); tick();
        mem_ready = 1'b1;
        acc = 1'b0;
        for (t = 0; t < 20 && !acc; t++) begin
            @(negedge clock);
            acc = plot_ready;
            tick();
        end
        plot = 1'b0;
        check("t2_fifth_accepted", acc, 1);
        wait_idle(50, "t2_idle");

        // Out-of-range requests are accepted and dropped
        plot = 1'b1; x = 8'd160; y = 7'd0; colour = 3'd7;
        tick();
        x = 8'd0; y = 7'd120;
        tick();
        plot = 1'b0;
        tick(); tick(); tick();
        check("t3_busy", busy, 0);
`ifdef PLOT_SINK_DROP_CNT_EN
        check("t3_drop_count", drop_count, 2);
`endif

        // Randomized plots with a randomly stalling memory
        for (int i = 0; i < 400; i++) begin
            plot      = ($urandom_range(0, 9) < 7);
            x         = 8'($urandom_range(0, 175));
            y         = 7'($urandom_range(0, 127));
            colour    = 3'($urandom);
            mem_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        plot = 1'b0; mem_ready = 1'b1;
        wait_idle(100, "rand_idle");

        // Full clear from idle
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t4_ready_in_clear", plot_ready, 0);
        check("t4_we_in_clear", mem_we, 1);
        wait_idle(NPIX + 50, "t4_idle");

        // Clear requested while a write is stalled with two more queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot = 1'b1; x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
            colour = 3'($urandom);
            tick();
        end
        plot = 1'b0;
        t = 0;
        while (mem_we !== 1'b1 && t < 10) begin tick(); t++; end
        check("t5_writing", mem_we, 1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t5_ready_pending", plot_ready, 1);
        mem_ready = 1'b1;
        wait_idle(NPIX + 50, "t5_idle");

        // Reset in the middle of a clear
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        t = 0;
        while (mem_addr !== 15'd5000 && t < 6000) begin tick(); t++; end
        check("t6_reached_5000", mem_addr, 5000);
        reset = 1'b1;
        #1;
        check("t6_we", mem_we, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_data", mem_data, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", plot_ready, 1);
        tick(); tick();
        reset = 1'b0;
        repeat (20) tick();
        check("t6_ready_after", plot_ready, 1);
        check("t6_we_after", mem_we, 0);
        check("t6_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface. Game datapaths drive x/y/colour/plot into it.
- Buffers plot requests in a small FIFO and range-checks coordinates.
- Converts each in-range request to a linear framebuffer address and issues writes to a memory write port that can stall.
- Also provides a full-screen clear sequence for game reset and round transitions.

Parameters:
- WIDTH, 160, visible columns.
- HEIGHT, 120, visible rows.
- FIFO_DEPTH, 4, plot request buffer entries; must be a power of two and at least 2.
- CLEAR_COLOUR, 3'b000, colour written during a clear.

Ports:
- clock  in  1  system clock, CLOCK_50 domain.
- reset  in  1  asynchronous, active-high reset.
- x  in  8  plot column.
- y  in  7  plot row.
- colour  in  3  RGB, 1 bit per channel.
- plot  in  1  plot request; accepted on the edge where plot & plot_ready.
- plot_ready  out  1  FIFO not full and no clear in progress.
- clear_req  in  1  one-cycle pulse; starts a full-screen clear.
- busy  out  1  high while the FIFO is non-empty or a clear is running.
- mem_addr  out  15  linear address, y*WIDTH+x.
- mem_data  out  3  write colour.
- mem_we  out  1  write strobe.
- mem_ready  in  1  the write completes on the edge where mem_we & mem_ready.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 except plot_ready=1. FIFO empty, FSM in IDLE.
- Reset asserted mid-operation discards all pending writes and any clear in progress.
- Accept: when plot & plot_ready, {x,y,colour} is pushed on that edge.
- Drop rule: requests with x>=WIDTH or y>=HEIGHT are accepted (ready honoured) but not pushed.
- Address arithmetic: y*160 is computed as (y<<7)+(y<<5), plus x, zero-extended to 15 bits. Maximum value is 19199.
- FSM states:
  - IDLE: mem_we=0.
    - If clear_req, go to CLEAR; clear_req takes priority over a non-empty FIFO.
    - Else if the FIFO is non-empty, go to WRITE.
  - WRITE: mem_we=1 with the FIFO head registered on mem_addr/mem_data.
    - On mem_ready, pop the entry.
    - If the FIFO is still non-empty after the pop, present the next head the following cycle and stay in WRITE; else go to IDLE.
    - A clear_req arriving during WRITE is latched as clear_pend. It is serviced after the current write completes, before the remaining FIFO entries.
  - CLEAR: counter runs 0..WIDTH*HEIGHT-1. mem_we=1, mem_data=CLEAR_COLOUR, mem_addr=counter.
    - Advance only on mem_ready; wrap to IDLE after address 19199 is written.
    - plot_ready=0 throughout CLEAR. A clear_req during CLEAR is ignored.
- Latency: a plot accepted into an empty FIFO while in IDLE gives mem_we high 2 cycles later (push edge, then the state-transition edge).
- FIFO full: plot_ready drops combinationally from the full flag.
  - A push and a pop on the same edge while full is not possible, because ready is low.
  - A push and a pop on the same edge while non-full leaves the count unchanged.
- mem_addr/mem_data must be held stable while mem_we & !mem_ready (stall).
- busy = (FSM!=IDLE) | fifo_nonempty | clear_pend.

Optional Feature:
- Macro: PLOT_SINK_DROP_CNT_EN.
- Enabled:
  - Adds output drop_count[7:0], which counts out-of-range plot requests accepted.
  - Saturates at 255; cleared by reset and at the start of each clear sequence.
- Disabled: port absent, counter not synthesised, drop behaviour unchanged.

Decomposition:
- Shared package/header holds:
  - SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15.
  - Colour width 3.
  - FSM state encodings IDLE/WRITE/CLEAR.
- One sub-module: plot_fifo, a synchronous FIFO with FIFO_DEPTH entries, data width 18, full/empty flags and same-cycle push/pop.

Test Plan:
1. Single plot x=10, y=5, colour=3'b011, mem_ready tied 1 -> one write with mem_addr=810, mem_data=3, 2 cycles after accept; busy returns low.
2. Five back-to-back plots with mem_ready=0 -> plot_ready low after the 4th accept. Release mem_ready -> 4 writes in order, then the 5th is accepted and written.
3. Plots (160,0) and (0,120) -> accepted, no mem_we. With PLOT_SINK_DROP_CNT_EN, drop_count=2.
4. clear_req with mem_ready=1 -> exactly 19200 writes of CLEAR_COLOUR, addresses 0..19199 in order, plot_ready=0 throughout, then IDLE.
5. clear_req during WRITE with 2 entries queued -> current write completes, full clear runs, then the 2 queued writes are issued.
6. Assert reset mid-clear at address 5000 -> all outputs return to reset values immediately. No further writes; plot_ready=1.
